truth_table_bist: RTL
=====================

// Module: truth_table_bist
// PURPOSE
//   Synthesizable hardware tester for the 3-in/3-out combinational "complex" logic.
//   - On start: sweeps the 3-bit stimulus x_out through 0..7.
//   - Per vector: waits a settle window, samples z_0/z_1/z_2, compares them with the truth-table parameters.
//   - Reports error count and pass/done.
//   Sits beside the DUT: x_out drives the DUT's x_in; the DUT's z outputs return to z_0..z_2.
// PARAMETERS
//   TT0        8'b00111001  expected z_0; bit [v] = value for stimulus v
//   TT1        8'b10110010  expected z_1; bit [v] = value for stimulus v
//   TT2        8'b01011100  expected z_2; bit [v] = value for stimulus v
//   SETTLE_CYC 6            cycles x_out is held before sampling; legal range 1..15
// PORTS
//   clk      in   1  clock, rising edge
//   rst_n    in   1  reset, asynchronous, active-low
//   start    in   1  begin sweep; honoured only when busy=0
//   x_out    out  3  stimulus to DUT x_in
//   z_0      in   1  DUT output 0
//   z_1      in   1  DUT output 1
//   z_2      in   1  DUT output 2
//   busy     out  1  sweep in progress
//   done     out  1  sweep complete; held until next accepted start
//   pass     out  1  valid when done=1; 1 = zero mismatching vectors
//   err_cnt  out  4  number of mismatching vectors (0..8)
//   fail_map out  8  bit v = vector v mismatched (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - state=IDLE; all outputs 0: x_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_map=0.
//     - Counters cleared.
//     - Reset mid-sweep aborts the sweep immediately; no partial result is retained.
//   FSM states: IDLE, SETTLE, CHECK.
//   IDLE
//     - busy=0.
//     - start=1 at edge E0 -> SETTLE.
//     - At E0: x_out=0, vec=0, settle counter=SETTLE_CYC-1, busy=1; clear done, pass, err_cnt, fail_map.
//   SETTLE
//     - Holds x_out for exactly SETTLE_CYC cycles (counter decrements to 0), then -> CHECK.
//   CHECK (1 cycle)
//     - Compare {z_2,z_1,z_0} with {TT2[vec],TT1[vec],TT0[vec]}.
//     - Any bit differs -> err_cnt += 1. Exactly one count per vector, however many bits differ.
//     - vec<7: vec+1, x_out+1, counter reload -> SETTLE.
//     - vec==7 -> IDLE; busy=0, done=1, pass=(final err_cnt==0), including the vec-7 result.
//   Timing
//     - Each vector occupies SETTLE_CYC+1 cycles.
//     - done rises at edge E0 + 8*(SETTLE_CYC+1); default 56.
//     - x_out changes only on the edge leaving CHECK.
//   start rules
//     - start while busy=1 is ignored.
//     - start held high continuously restarts a new sweep on the edge after done rises; done pulses for 1 cycle.
//   Inputs: z_* sampled directly (same-clock combinational DUT; no synchronizer).
//   Width: err_cnt max 8, never overflows; vec is 3 bits; x_out equals vec.
// CONFIGURATION
//   FAIL_MAP_EN defined
//     - fail_map[vec] set to 1 in CHECK on mismatch.
//     - Cleared on accepted start and on reset.
//     - Held with done.
//   FAIL_MAP_EN undefined
//     - fail_map tied to 8'h00; no map storage.
//     - All other behaviour identical.
// TESTING
//   1 Golden DUT model, start at E0
//     -> x_out steps 0..7, each held 7 cycles
//     -> done=1 at E0+56, pass=1, err_cnt=0, fail_map=8'h00.
//   2 z_2 inverted on all vectors
//     -> err_cnt=8, pass=0, fail_map=8'hFF (EN) / 8'h00 (no EN).
//   3 z_0 wrong only at x=5, plus z_0 and z_1 both wrong at x=2
//     -> err_cnt=2, pass=0, fail_map=8'b00100100 (EN).
//   4 rst_n low while x_out=3 in SETTLE
//     -> all outputs 0 immediately.
//     -> A later start runs a full 56-cycle sweep with the golden result.
//   5 start pulsed at E0+20 during sweep
//     -> ignored; done still at E0+56, x_out sequence unchanged.
//   6 SETTLE_CYC=1, golden DUT
//     -> done at E0+16.
//     -> Then start held high: done high 1 cycle, err_cnt/fail_map cleared, new sweep begins.

Source files
------------

// File: rtl/truth_table_bist.sv
// truth_table_bist: sweeps a 3-bit stimulus, samples the DUT outputs after a settle window and counts mismatches.
// Optional FAIL_MAP_EN keeps a per-vector mismatch map on fail_map.
module truth_table_bist #(
    parameter logic [7:0] TT0        = 8'b00111001,
    parameter logic [7:0] TT1        = 8'b10110010,
    parameter logic [7:0] TT2        = 8'b01011100,
    parameter int         SETTLE_CYC = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] x_out,
    input  logic       z_0,
    input  logic       z_1,
    input  logic       z_2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_map
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);
    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       miss;
    always_comb begin
        miss    = {z_2, z_1, z_0} != {TT2[vec_q], TT1[vec_q], TT0[vec_q]};
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = 3'd0;
                    cnt_d   = RELOAD;
                    err_d   = 4'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = CHECK;
                else cnt_d = cnt_q - 4'd1;
            end
            CHECK: begin
                err_d = err_q + {3'b000, miss};
                if (vec_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pass_d  = err_d == 4'd0;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
`ifdef FAIL_MAP_EN
    logic [7:0] map_q, map_d;
    always_comb begin
        map_d = map_q;
        if (state_q == IDLE && start) map_d = 8'h00;
        else if (state_q == CHECK && miss) map_d[vec_q] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) map_q <= 8'h00;
        else map_q <= map_d;
    end
    assign fail_map = map_q;
`else
    assign fail_map = 8'h00;
`endif
    assign x_out   = vec_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
endmodule
